// File: rtl/cam_cfg_pkg.sv
// Shared types and defaults for the camera register-table sequencer.
// Pure declarations: no logic, no latency.
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_BUS,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } state_e;

  // Table words are at most 32 bits; the end marker is the all-ones word of the actual width.
  localparam logic [31:0] END_MARKER     = 32'hFFFF_FFFF;
  localparam logic [15:0] DEF_DELAY_ADDR = 16'hFFFE;
  localparam int unsigned DEF_DELAY_UNIT = 25000;
  localparam int unsigned DEF_MAX_RETRY  = 3;

  // Bits needed to hold the longest delay: (2^data_w - 1) * unit.
  function automatic int unsigned delay_cnt_w(input int unsigned data_w, input int unsigned unit);
    longint unsigned max_v;
    max_v = ((64'd1 << data_w) - 64'd1) * 64'(unit);
    return (max_v == 64'd0) ? 1 : $clog2(max_v + 64'd1);
  endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter for table delay entries; load takes effect next cycle.
// Counts while i_Count is high, saturating at zero; never stalls anything itself.
module cfg_delay_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Load,
  input  logic [CNT_W-1:0] i_Load_Val,
  input  logic             i_Count,
  output logic             o_Zero,
  output logic             o_Last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_Load) begin
      cnt_d = i_Load_Val;
    end else if (i_Count && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_Zero = (cnt_q == '0);
  // High on the final counting cycle, so a load of N spends exactly N cycles counting.
  assign o_Last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/cam_config_seq.sv
// Walks a {addr,value} register table, issuing SCCB writes with NACK retry and inline delays.
// Two cycles per fetched entry; stalls in ISSUE/WAIT_BUS until the SCCB master reports ready.
module cam_config_seq
  import cam_cfg_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 8,
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       DEPTH      = 128,
  parameter int unsigned       IDX_W      = $clog2(DEPTH),
  parameter logic [ADDR_W-1:0] DELAY_ADDR = DEF_DELAY_ADDR[ADDR_W-1:0],
  parameter int unsigned       DELAY_UNIT = DEF_DELAY_UNIT,
  parameter int unsigned       MAX_RETRY  = DEF_MAX_RETRY
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     i_Start,
  input  logic                     i_Abort,
  output logic [IDX_W-1:0]         o_Rom_Addr,
  input  logic [ADDR_W+DATA_W-1:0] i_Rom_Data,
  output logic                     o_Sccb_fStart,
  output logic [ADDR_W-1:0]        o_Sccb_Addr,
  output logic [DATA_W-1:0]        o_Sccb_Data,
  input  logic                     i_Sccb_fReady,
  input  logic                     i_Sccb_Nack,
  output logic                     o_Busy,
  output logic                     o_Done,
  output logic                     o_Error,
  output logic [IDX_W-1:0]         o_Index
);

  localparam int unsigned WORD_W  = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = delay_cnt_w(DATA_W, DELAY_UNIT);
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   rom_addr_q, rom_addr_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [ADDR_W-1:0]  sccb_addr_q, sccb_addr_d;
  logic [DATA_W-1:0]  sccb_data_q, sccb_data_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               first_q, first_d;
  logic               busy_q;
  logic               go_next;

  logic [ADDR_W-1:0]  word_addr;
  logic [DATA_W-1:0]  word_val;
  logic               word_end;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_load_val;
  logic               tmr_count;
  logic               tmr_zero;
  logic               tmr_last;

  assign word_addr    = i_Rom_Data[WORD_W-1 -: ADDR_W];
  assign word_val     = i_Rom_Data[DATA_W-1:0];
  assign word_end     = (i_Rom_Data == END_MARKER[WORD_W-1:0]);
  assign tmr_load_val = CNT_W'(word_val) * CNT_W'(DELAY_UNIT);
  assign tmr_count    = (state_q == ST_DELAY);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rom_addr_d  = rom_addr_q;
    retry_d     = retry_q;
    sccb_addr_d = sccb_addr_q;
    sccb_data_d = sccb_data_q;
    done_d      = done_q;
    error_d     = error_q;
    first_d     = first_q;
    go_next     = 1'b0;
    tmr_load    = 1'b0;

    if (i_Abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_Start) begin
            idx_d      = '0;
            rom_addr_d = '0;
            retry_d    = '0;
            done_d     = 1'b0;
            error_d    = 1'b0;
            state_d    = ST_FETCH;
          end
        end
        ST_FETCH: state_d = ST_DECODE;
        ST_DECODE: begin
          if (word_end) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (word_addr == DELAY_ADDR) begin
            if (word_val == '0) begin
              go_next = 1'b1;
            end else begin
              tmr_load = 1'b1;
              state_d  = ST_DELAY;
            end
          end else begin
            sccb_addr_d = word_addr;
            sccb_data_d = word_val;
            state_d     = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (i_Sccb_fReady) begin
            first_d = 1'b1;
            state_d = ST_WAIT_BUS;
          end
        end
        ST_WAIT_BUS: begin
          // The master may still show ready on the cycle right after the request.
          if (first_q) begin
            first_d = 1'b0;
          end else if (i_Sccb_fReady) begin
            if (!i_Sccb_Nack) begin
              go_next = 1'b1;
            end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = ST_ISSUE;
            end else begin
              error_d = 1'b1;
              state_d = ST_ERROR;
            end
          end
        end
        ST_DELAY: begin
          if (tmr_last || tmr_zero) begin
            go_next = 1'b1;
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        ST_ERROR: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase

      if (go_next) begin
        retry_d = '0;
        if (idx_q == LAST_IDX) begin
          error_d = 1'b1;
          state_d = ST_ERROR;
        end else begin
          idx_d      = idx_q + IDX_W'(1);
          rom_addr_d = idx_q + IDX_W'(1);
          state_d    = ST_FETCH;
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      rom_addr_q  <= '0;
      retry_q     <= '0;
      sccb_addr_q <= '0;
      sccb_data_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      first_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rom_addr_q  <= rom_addr_d;
      retry_q     <= retry_d;
      sccb_addr_q <= sccb_addr_d;
      sccb_data_q <= sccb_data_d;
      done_q      <= done_d;
      error_q     <= error_d;
      first_q     <= first_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  cfg_delay_timer #(
    .CNT_W(CNT_W)
  ) u_delay_timer (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Load     (tmr_load),
    .i_Load_Val (tmr_load_val),
    .i_Count    (tmr_count),
    .o_Zero     (tmr_zero),
    .o_Last     (tmr_last)
  );

  // Gated by the live ready so a request can never reach a busy master.
  assign o_Sccb_fStart = (state_q == ST_ISSUE) && i_Sccb_fReady && !i_Abort;
  assign o_Rom_Addr    = rom_addr_q;
  assign o_Sccb_Addr   = sccb_addr_q;
  assign o_Sccb_Data   = sccb_data_q;
  assign o_Busy        = busy_q;
  assign o_Done        = done_q;
  assign o_Error       = error_q;
  assign o_Index       = idx_q;

endmodule

// File: tb/tb_cam_config_seq.sv
// Bench for cam_config_seq: ROM and SCCB slave models, directed cases, then randomized tables
// checked against a table-walking reference model.
module tb_cam_config_seq;

  localparam int DEPTH = 4;
  localparam int UNIT  = 10;
  localparam int MAXR  = 3;

  logic        i_Clk, i_Rst, i_Start, i_Abort;
  logic [1:0]  o_Rom_Addr, o_Index;
  logic [15:0] i_Rom_Data;
  logic        o_Sccb_fStart, i_Sccb_fReady, i_Sccb_Nack;
  logic [7:0]  o_Sccb_Addr, o_Sccb_Data;
  logic        o_Busy, o_Done, o_Error;

  cam_config_seq #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .IDX_W(2),
    .DELAY_ADDR(8'hFE), .DELAY_UNIT(UNIT), .MAX_RETRY(MAXR)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Abort(i_Abort),
    .o_Rom_Addr(o_Rom_Addr), .i_Rom_Data(i_Rom_Data),
    .o_Sccb_fStart(o_Sccb_fStart), .o_Sccb_Addr(o_Sccb_Addr), .o_Sccb_Data(o_Sccb_Data),
    .i_Sccb_fReady(i_Sccb_fReady), .i_Sccb_Nack(i_Sccb_Nack),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Error(o_Error), .o_Index(o_Index)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  logic [15:0] rom [0:DEPTH-1];
  int          nk  [0:DEPTH-1];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  bit          nack_plan[$];
  logic        exp_done, exp_err;
  int          errors = 0;
  int          checks = 0;
  int          viol = 0;
  int          hold_lat = 0;

  bit          sl_st;
  logic [15:0] sl_wa;
  int          sl_busy;
  bit          sl_nack;

  // Synchronous ROM: word appears the cycle after the address.
  always @(negedge i_Clk) i_Rom_Data = rom[o_Rom_Addr];

  always @(posedge i_Clk) if (o_Sccb_fStart && !i_Sccb_fReady) viol++;

  // SCCB slave: accepts a request, goes busy, then reports ready with the planned ACK/NACK.
  initial begin
    i_Sccb_fReady = 1'b1;
    i_Sccb_Nack   = 1'b0;
    sl_busy       = 0;
    sl_nack       = 1'b0;
    forever begin
      @(posedge i_Clk);
      sl_st = o_Sccb_fStart;
      sl_wa = {o_Sccb_Addr, o_Sccb_Data};
      @(negedge i_Clk);
      if (sl_st) begin
        got_q.push_back(sl_wa);
        sl_nack = (nack_plan.size() > 0) ? nack_plan.pop_front() : 1'b0;
        i_Sccb_fReady = 1'b0;
        i_Sccb_Nack   = 1'b0;
        sl_busy = (hold_lat > 0) ? hold_lat : int'($urandom_range(1, 4));
      end else if (!i_Sccb_fReady) begin
        if (sl_busy > 1) sl_busy--;
        else begin
          i_Sccb_fReady = 1'b1;
          i_Sccb_Nack   = sl_nack;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: walk the table as a list of entries; each write takes attempts until the first
  // ACK, at most 1+MAXR of them; running off the end of the table is an error.
  task automatic model();
    int idx;
    bit fin, nxt;
    logic [15:0] w;
    exp_q.delete();
    nack_plan.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    idx = 0;
    fin = 1'b0;
    while (!fin) begin
      w   = rom[idx];
      nxt = 1'b0;
      if (w == 16'hFFFF) begin
        exp_done = 1'b1;
        fin = 1'b1;
      end else if (w[15:8] == 8'hFE) begin
        nxt = 1'b1;
      end else begin
        for (int a = 0; a <= MAXR; a++) begin
          exp_q.push_back(w);
          nack_plan.push_back(a < nk[idx]);
          if (a >= nk[idx]) begin
            nxt = 1'b1;
            break;
          end
        end
        if (!nxt) begin
          exp_err = 1'b1;
          fin = 1'b1;
        end
      end
      if (nxt) begin
        if (idx == DEPTH - 1) begin
          exp_err = 1'b1;
          fin = 1'b1;
        end else idx++;
      end
    end
  endtask

  task automatic set_rom(input logic [15:0] a, b, c, d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    for (int i = 0; i < DEPTH; i++) nk[i] = 0;
    nack_plan.delete();
  endtask

  task automatic pulse_start();
    got_q.delete();
    @(negedge i_Clk); i_Start = 1'b1;
    @(negedge i_Clk); i_Start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (o_Busy && n < 3000) begin
      @(negedge i_Clk);
      n++;
    end
    check({tag, "_timeout"}, (n < 3000), 1);
  endtask

  task automatic compare_run(input string tag);
    check({tag, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_wr"}, got_q[i], exp_q[i]);
    check({tag, "_done"}, o_Done, exp_done);
    check({tag, "_err"}, o_Error, exp_err);
    check({tag, "_busy"}, o_Busy, 0);
  endtask

  initial begin
    int n;
    int r;
    logic [15:0] e [0:DEPTH-1];
    i_Rst = 1'b1; i_Start = 1'b0; i_Abort = 1'b0;
    set_rom(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    #2 i_Rst = 1'b0;
    #1;
    check("rst_busy", o_Busy, 0);
    check("rst_done", o_Done, 0);
    check("rst_err", o_Error, 0);
    check("rst_fstart", o_Sccb_fStart, 0);
    check("rst_romaddr", o_Rom_Addr, 0);
    check("rst_index", o_Index, 0);
    check("rst_sccb", {o_Sccb_Addr, o_Sccb_Data}, 0);
    @(negedge i_Clk); @(negedge i_Clk);
    i_Rst = 1'b1;

    // Two plain writes then end marker.
    set_rom(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
    pulse_start();
    check("basic_busy_rise", o_Busy, 1);
    wait_idle("basic");
    check("basic_nwr", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check("basic_wr0", got_q[0], 16'h1280);
      check("basic_wr1", got_q[1], 16'h1101);
    end
    check("basic_done", o_Done, 1);
    check("basic_err", o_Error, 0);
    check("basic_busy", o_Busy, 0);

    // Abort beats start in the same cycle.
    @(negedge i_Clk); i_Start = 1'b1; i_Abort = 1'b1;
    @(negedge i_Clk); i_Start = 1'b0; i_Abort = 1'b0;
    check("abort_wins_busy", o_Busy, 0);
    check("abort_wins_done", o_Done, 1);

    // Delay entry of 3 units: FETCH + DECODE + 30 DELAY cycles before entry 1 is fetched.
    set_rom(16'hFE03, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    pulse_start();
    n = 0;
    while (o_Index == 2'd0 && n < 200) begin
      @(negedge i_Clk);
      n++;
    end
    check("delay_cycles", n, 2 + 3 * UNIT);
    check("delay_no_write", got_q.size(), 0);
    wait_idle("delay");
    check("delay_done", o_Done, 1);

    // Two NACKs then ACK on entry 0.
    set_rom(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    nack_plan = '{1'b1, 1'b1, 1'b0};
    pulse_start();
    wait_idle("retry");
    check("retry_nwr", got_q.size(), 3);
    check("retry_done", o_Done, 1);
    check("retry_err", o_Error, 0);

    // Persistent NACK exhausts retries.
    set_rom(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    nack_plan = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    pulse_start();
    wait_idle("nackall");
    check("nackall_nwr", got_q.size(), 4);
    check("nackall_err", o_Error, 1);
    check("nackall_done", o_Done, 0);
    nack_plan.delete();

    // Full table without end marker.
    set_rom(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    pulse_start();
    wait_idle("noend");
    check("noend_nwr", got_q.size(), 4);
    check("noend_err", o_Error, 1);
    check("noend_done", o_Done, 0);

    // Abort while waiting on the bus, then rerun from index 0.
    set_rom(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
    hold_lat = 20;
    pulse_start();
    n = 0;
    while (got_q.size() < 2 && n < 500) begin
      @(negedge i_Clk);
      n++;
    end
    check("abort_reach", (n < 500), 1);
    i_Abort = 1'b1;
    @(negedge i_Clk); i_Abort = 1'b0;
    check("abort_busy", o_Busy, 0);
    check("abort_done", o_Done, 0);
    check("abort_err", o_Error, 0);
    check("abort_index", o_Index, 1);
    hold_lat = 0;
    pulse_start();
    check("rerun_index", o_Index, 0);
    wait_idle("rerun");
    check("rerun_nwr", got_q.size(), 2);
    if (got_q.size() >= 1) check("rerun_wr0", got_q[0], 16'h1280);
    check("rerun_done", o_Done, 1);

    // Asynchronous reset in the middle of a delay.
    set_rom(16'h1280, 16'hFE03, 16'hFFFF, 16'hFFFF);
    pulse_start();
    n = 0;
    while (o_Index != 2'd1 && n < 200) begin
      @(negedge i_Clk);
      n++;
    end
    repeat (3) @(negedge i_Clk);
    check("pre_rst_busy", o_Busy, 1);
    check("pre_rst_romaddr", o_Rom_Addr, 1);
    check("pre_rst_sccb", {o_Sccb_Addr, o_Sccb_Data}, 16'h1280);
    #2 i_Rst = 1'b0;
    #1;
    check("mid_rst_busy", o_Busy, 0);
    check("mid_rst_done", o_Done, 0);
    check("mid_rst_err", o_Error, 0);
    check("mid_rst_romaddr", o_Rom_Addr, 0);
    check("mid_rst_index", o_Index, 0);
    check("mid_rst_sccb", {o_Sccb_Addr, o_Sccb_Data}, 0);
    check("mid_rst_fstart", o_Sccb_fStart, 0);
    @(negedge i_Clk); i_Rst = 1'b1;

    // Randomized tables against the reference model.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        r = int'($urandom_range(0, 9));
        if (r <= 5 || r == 9) e[i] = {8'($urandom_range(0, 253)), 8'($urandom)};
        else if (r <= 7)      e[i] = {8'hFE, 8'($urandom_range(0, 3))};
        else                  e[i] = 16'hFFFF;
      end
      set_rom(e[0], e[1], e[2], e[3]);
      for (int i = 0; i < DEPTH; i++) begin
        r = int'($urandom_range(0, 5));
        nk[i] = (r <= 2) ? 0 : (r == 3) ? 1 : (r == 4) ? 2 : 4;
      end
      model();
      pulse_start();
      wait_idle("rand");
      compare_run("rand");
    end

    check("fstart_while_busy", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
